tof_clks: RTL and testbench

Three-channel programmable modulation-clock generator for the time-of-flight pixel path. It runs a period counter on the system clock while the exposure logic asserts `VALID`. It derives three square-wave outputs from that counter, each with its own duty and delay: the FPGA demodulation references at 0° and 90°, and the laser modulation. It sits between the exposure controller and the sensor/laser pins and is configured from the variable register file.

---
 rtl/tof_clks_pkg.sv | 13 +
 rtl/tof_clks_phase.sv | 42 ++++
 rtl/tof_clks.sv | 103 ++++++++++
 tb/tb_tof_clks.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tof_clks_pkg.sv
// Shared constants and types for the tof_clks modulation-clock generator.
// Channel fields default to CNT_W_DEF bits wide.
package tof_clks_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int N_CH      = 3;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] duty;
        logic [CNT_W_DEF-1:0] delay;
    } ch_cfg_t;

endpackage

// File: rtl/tof_clks_phase.sv
// One modulation channel: clamps delay, derives the channel phase from the shared
// period counter and registers the duty compare as the channel output.
module tof_clks_phase
    import tof_clks_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] duty,
    output logic             clk_out
);

    logic [CNT_W-1:0] delay_eff;
    logic [CNT_W:0]   phase;
    logic             hit;

    // A delay of a full period or more wraps to no delay at all; the phase sum is
    // taken one bit wider so cnt + period never overflows.
    always_comb begin
        delay_eff = (delay >= period) ? '0 : delay;
        if (cnt >= delay_eff)
            phase = {1'b0, cnt - delay_eff};
        else
            phase = {1'b0, cnt} + {1'b0, period} - {1'b0, delay_eff};
        hit = (period != '0) && (phase < {1'b0, duty});
    end

    always_ff @(posedge clk) begin
        if (rst)
            clk_out <= 1'b0;
        else if (valid)
            clk_out <= hit;
        else
            clk_out <= 1'b0;
    end

endmodule

// File: rtl/tof_clks.sv
// Three-channel ToF modulation clock generator: shared period counter plus one phase
// channel per output. Define TOF_CLKS_SHADOW_EN to double-buffer the configuration.
module tof_clks
    import tof_clks_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLKIN,
    input  logic             rst,
    input  logic             VALID,
    input  logic [CNT_W-1:0] PERIOD,
    input  logic [CNT_W-1:0] DUTY1,
    input  logic [CNT_W-1:0] DUTY2,
    input  logic [CNT_W-1:0] DUTY3,
    input  logic [CNT_W-1:0] DELAY1,
    input  logic [CNT_W-1:0] DELAY2,
    input  logic [CNT_W-1:0] DELAY3,
    output logic             CLKOUT1,
    output logic             CLKOUT2,
    output logic             CLKOUT3
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty      [N_CH];
    logic [CNT_W-1:0] delay     [N_CH];
    logic [CNT_W-1:0] duty_in   [N_CH];
    logic [CNT_W-1:0] delay_in  [N_CH];
    logic             clk_out   [N_CH];

    assign duty_in[0]  = DUTY1;
    assign duty_in[1]  = DUTY2;
    assign duty_in[2]  = DUTY3;
    assign delay_in[0] = DELAY1;
    assign delay_in[1] = DELAY2;
    assign delay_in[2] = DELAY3;

`ifdef TOF_CLKS_SHADOW_EN
    logic [CNT_W-1:0] period_sh;
    logic [CNT_W-1:0] duty_sh  [N_CH];
    logic [CNT_W-1:0] delay_sh [N_CH];
    logic             load;

    // New settings are only taken while idle or at a period boundary so a running
    // pulse is never cut short.
    assign load = !VALID || (cnt == period_sh - ONE) || (period_sh == '0);

    always_ff @(posedge CLKIN) begin
        if (rst) begin
            period_sh <= '0;
            for (int i = 0; i < N_CH; i++) begin
                duty_sh[i]  <= '0;
                delay_sh[i] <= '0;
            end
        end else if (load) begin
            period_sh <= PERIOD;
            for (int i = 0; i < N_CH; i++) begin
                duty_sh[i]  <= duty_in[i];
                delay_sh[i] <= delay_in[i];
            end
        end
    end

    assign period = period_sh;
    assign duty   = duty_sh;
    assign delay  = delay_sh;
`else
    assign period = PERIOD;
    assign duty   = duty_in;
    assign delay  = delay_in;
`endif

    always_ff @(posedge CLKIN) begin
        if (rst)
            cnt <= '0;
        else if (!VALID || period == '0 || cnt == period - ONE)
            cnt <= '0;
        else
            cnt <= cnt + ONE;
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tof_clks_phase #(
            .CNT_W (CNT_W)
        ) u_phase (
            .clk     (CLKIN),
            .rst     (rst),
            .valid   (VALID),
            .cnt     (cnt),
            .period  (period),
            .delay   (delay[g]),
            .duty    (duty[g]),
            .clk_out (clk_out[g])
        );
    end

    assign CLKOUT1 = clk_out[0];
    assign CLKOUT2 = clk_out[1];
    assign CLKOUT3 = clk_out[2];

endmodule

// File: tb/tb_tof_clks.sv
// Self-checking bench for tof_clks: a table of hand-computed vectors plus directed
// sequences for gating, reset, long-run and reconfiguration behaviour.
module tb_tof_clks;
    import tof_clks_pkg::*;

    logic       CLKIN = 1'b0;
    logic       rst;
    logic       VALID;
    logic [7:0] PERIOD;
    logic [7:0] DUTY1, DUTY2, DUTY3;
    logic [7:0] DELAY1, DELAY2, DELAY3;
    logic       CLKOUT1, CLKOUT2, CLKOUT3;

    int n_checks = 0;
    int n_fail   = 0;

    tof_clks #(.CNT_W(8)) dut (
        .CLKIN   (CLKIN),
        .rst     (rst),
        .VALID   (VALID),
        .PERIOD  (PERIOD),
        .DUTY1   (DUTY1),
        .DUTY2   (DUTY2),
        .DUTY3   (DUTY3),
        .DELAY1  (DELAY1),
        .DELAY2  (DELAY2),
        .DELAY3  (DELAY3),
        .CLKOUT1 (CLKOUT1),
        .CLKOUT2 (CLKOUT2),
        .CLKOUT3 (CLKOUT3)
    );

    always #5 CLKIN = ~CLKIN;

    typedef struct {
        string      name;
        logic [7:0] period;
        ch_cfg_t    ch1, ch2, ch3;
        int         k;
        logic       o1, o2, o3;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, int p, int w1, int w2, int w3,
                                int d1, int d2, int d3, int k,
                                bit o1, bit o2, bit o3, int c);
        vec_t v;
        v.name = name;
        v.period = 8'(p);
        v.ch1 = '{duty: 8'(w1), delay: 8'(d1)};
        v.ch2 = '{duty: 8'(w2), delay: 8'(d2)};
        v.ch3 = '{duty: 8'(w3), delay: 8'(d3)};
        v.k = k;
        v.o1 = o1; v.o2 = o2; v.o3 = o3;
        v.exp_cnt = 8'(c);
        return v;
    endfunction

    // Advance n rising edges; returns 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLKIN);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] p, input ch_cfg_t c1, input ch_cfg_t c2,
                                 input ch_cfg_t c3);
        PERIOD = p;
        DUTY1 = c1.duty;  DELAY1 = c1.delay;
        DUTY2 = c2.duty;  DELAY2 = c2.delay;
        DUTY3 = c3.duty;  DELAY3 = c3.delay;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reset, load a configuration while idle, then raise VALID.
    task automatic start_run(input logic [7:0] p, input ch_cfg_t c1, input ch_cfg_t c2,
                             input ch_cfg_t c3);
        rst = 1'b1;
        VALID = 1'b0;
        step(1);
        rst = 1'b0;
        applyStimulus(p, c1, c2, c3);
        step(2);
        VALID = 1'b1;
    endtask

    ch_cfg_t q1, q2, q3;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        q1 = '{duty: 8'd50, delay: 8'd0};
        q2 = '{duty: 8'd50, delay: 8'd25};
        q3 = '{duty: 8'd50, delay: 8'd50};
        rst = 1'b1;
        VALID = 1'b0;
        applyStimulus(8'd0, q1, q1, q1);

        // Reset state
        step(2);
        checkOutput("reset_out1", int'(CLKOUT1), 0);
        checkOutput("reset_out2", int'(CLKOUT2), 0);
        checkOutput("reset_out3", int'(CLKOUT3), 0);
        checkOutput("reset_cnt", int'(dut.cnt), 0);

        // After k edges with VALID high: cnt = k mod P, outputs reflect c = (k-1) mod P
        vecs.push_back(mk("quad_k1",   100, 50, 50, 50, 0, 25, 50,   1, 1, 0, 0,  1));
        vecs.push_back(mk("quad_k26",  100, 50, 50, 50, 0, 25, 50,  26, 1, 1, 0, 26));
        vecs.push_back(mk("quad_k50",  100, 50, 50, 50, 0, 25, 50,  50, 1, 1, 0, 50));
        vecs.push_back(mk("quad_k51",  100, 50, 50, 50, 0, 25, 50,  51, 0, 1, 1, 51));
        vecs.push_back(mk("quad_k75",  100, 50, 50, 50, 0, 25, 50,  75, 0, 1, 1, 75));
        vecs.push_back(mk("quad_k76",  100, 50, 50, 50, 0, 25, 50,  76, 0, 0, 1, 76));
        vecs.push_back(mk("quad_k100", 100, 50, 50, 50, 0, 25, 50, 100, 0, 0, 1,  0));
        vecs.push_back(mk("quad_k101", 100, 50, 50, 50, 0, 25, 50, 101, 1, 0, 0,  1));
        vecs.push_back(mk("quad_k226", 100, 50, 50, 50, 0, 25, 50, 226, 1, 1, 0, 26));
        vecs.push_back(mk("period0",     0, 50, 50, 50, 0, 25, 50,  30, 0, 0, 0,  0));
        vecs.push_back(mk("bound_k80", 100, 120, 0, 50, 0, 0, 150,  80, 1, 0, 0, 80));
        vecs.push_back(mk("bound_k10", 100, 120, 0, 50, 0, 0, 150,  10, 1, 0, 1, 10));
        vecs.push_back(mk("period1",     1,  1, 0, 1, 0, 0, 0,       5, 1, 0, 1,  0));
        vecs.push_back(mk("p10_k3",     10,  3, 5, 10, 8, 2, 4,      3, 0, 1, 1,  3));
        vecs.push_back(mk("p10_k9",     10,  3, 5, 10, 8, 2, 4,      9, 1, 0, 1,  9));

        foreach (vecs[i]) begin
            start_run(vecs[i].period, vecs[i].ch1, vecs[i].ch2, vecs[i].ch3);
            step(vecs[i].k);
            checkOutput({vecs[i].name, "_out1"}, int'(CLKOUT1), int'(vecs[i].o1));
            checkOutput({vecs[i].name, "_out2"}, int'(CLKOUT2), int'(vecs[i].o2));
            checkOutput({vecs[i].name, "_out3"}, int'(CLKOUT3), int'(vecs[i].o3));
            checkOutput({vecs[i].name, "_cnt"},  int'(dut.cnt), int'(vecs[i].exp_cnt));
        end

        // Long quadrature run: 10 full periods, 50 high cycles each, ch3 = ~ch1
        begin
            int hi1 = 0, hi2 = 0, hi3 = 0, anti = 0;
            start_run(8'd100, q1, q2, q3);
            for (int i = 0; i < 1000; i++) begin
                step(1);
                hi1 += int'(CLKOUT1);
                hi2 += int'(CLKOUT2);
                hi3 += int'(CLKOUT3);
                if (CLKOUT3 !== ~CLKOUT1) anti++;
            end
            checkOutput("long_high1", hi1, 500);
            checkOutput("long_high2", hi2, 500);
            checkOutput("long_high3", hi3, 500);
            checkOutput("long_antiphase_errors", anti, 0);
        end

        // VALID dropped at cnt=37, then re-asserted
        start_run(8'd100, q1, q2, q3);
        step(37);
        checkOutput("gate_pre_cnt", int'(dut.cnt), 37);
        VALID = 1'b0;
        step(1);
        checkOutput("gate_low_out1", int'(CLKOUT1), 0);
        checkOutput("gate_low_out2", int'(CLKOUT2), 0);
        checkOutput("gate_low_out3", int'(CLKOUT3), 0);
        checkOutput("gate_low_cnt", int'(dut.cnt), 0);
        step(3);
        checkOutput("gate_idle_out1", int'(CLKOUT1), 0);
        VALID = 1'b1;
        step(1);
        checkOutput("gate_rise_out1", int'(CLKOUT1), 1);
        checkOutput("gate_rise_out2", int'(CLKOUT2), 0);
        checkOutput("gate_rise_cnt", int'(dut.cnt), 1);

        // Reset asserted mid-run at cnt=60
        start_run(8'd100, q1, q2, q3);
        step(60);
        checkOutput("rst_pre_out2", int'(CLKOUT2), 1);
        checkOutput("rst_pre_out3", int'(CLKOUT3), 1);
        rst = 1'b1;
        step(1);
        checkOutput("rst_out1", int'(CLKOUT1), 0);
        checkOutput("rst_out2", int'(CLKOUT2), 0);
        checkOutput("rst_out3", int'(CLKOUT3), 0);
        checkOutput("rst_cnt", int'(dut.cnt), 0);
        rst = 1'b0;

        // PERIOD 100 -> 40 and DUTY1 50 -> 20 at cnt=20
        start_run(8'd100, q1, q2, q3);
        step(20);
        PERIOD = 8'd40;
        DUTY1  = 8'd20;
`ifdef TOF_CLKS_SHADOW_EN
        step(15);
        checkOutput("shadow_e35_out1", int'(CLKOUT1), 1);
        step(64);
        checkOutput("shadow_e99_cnt", int'(dut.cnt), 99);
        step(1);
        checkOutput("shadow_e100_cnt", int'(dut.cnt), 0);
        step(20);
        checkOutput("shadow_e120_out1", int'(CLKOUT1), 1);
        step(1);
        checkOutput("shadow_e121_out1", int'(CLKOUT1), 0);
        step(18);
        checkOutput("shadow_e139_cnt", int'(dut.cnt), 39);
        step(1);
        checkOutput("shadow_e140_cnt", int'(dut.cnt), 0);
`else
        step(15);
        checkOutput("live_e35_out1", int'(CLKOUT1), 0);
        step(4);
        checkOutput("live_e39_cnt", int'(dut.cnt), 39);
        step(1);
        checkOutput("live_e40_cnt", int'(dut.cnt), 0);
        step(1);
        checkOutput("live_e41_out1", int'(CLKOUT1), 1);
        step(19);
        checkOutput("live_e60_out1", int'(CLKOUT1), 1);
        step(1);
        checkOutput("live_e61_out1", int'(CLKOUT1), 0);
        step(19);
        checkOutput("live_e80_cnt", int'(dut.cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
